ws2812_frame_scheduler: RTL and testbench

- Sequences a full WS2812 strip frame: fetches NUM_LEDS GRB words from a pixel RAM and applies global brightness scaling.
- Hands each word to the per-pixel 24-bit serializer via a load/busy handshake, then holds the line low for the latch (reset) gap.
- Frames start on software request or a periodic refresh tick.
- Sits between the pixel buffer and the pixel serializer; owns the strip data line.

---
 rtl/ws2812_pkg.sv | 45 ++++
 rtl/ws2812_refresh_timer.sv | 39 +++
 rtl/ws2812_frame_scheduler.sv | 168 ++++++++++++++++
 tb/tb_ws2812_frame_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_pkg
//  Description : Shared types, constants and the brightness-scaling helper
//                for the WS2812 frame scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package ws2812_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_KICK    = 3'd3,
        ST_WAIT    = 3'd4,
        ST_LATCH   = 3'd5
    } state_e;

    localparam int unsigned CLK_HZ               = 50_000_000;
    localparam int unsigned DEFAULT_RESET_CYCLES = 4000;   // 80 us at 50 MHz

    // GRB word channel bit ranges
    localparam int unsigned G_HI = 23;
    localparam int unsigned G_LO = 16;
    localparam int unsigned R_HI = 15;
    localparam int unsigned R_LO = 8;
    localparam int unsigned B_HI = 7;
    localparam int unsigned B_LO = 0;

    // c' = (c * (br + 1)) >> 8 ; br = 255 leaves the channel untouched
    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] br);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, br} + 16'd1);
        return prod[15:8];
    endfunction

    function automatic logic [23:0] scale_grb(input logic [23:0] pix, input logic [7:0] br);
        return {scale_chan(pix[G_HI:G_LO], br),
                scale_chan(pix[R_HI:R_LO], br),
                scale_chan(pix[B_HI:B_LO], br)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_refresh_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_refresh_timer
//  Description : Free-running 0..REFRESH_CYCLES-1 counter; tick is high in
//                the terminal-count cycle, i.e. once per refresh period.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_refresh_timer #(
    parameter int unsigned REFRESH_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic reset_n_i,
    output logic tick_o
);

    localparam int unsigned    CNT_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wrap at the terminal count, otherwise increment
    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    // Counter register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/ws2812_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_frame_scheduler
//  Description : Walks the pixel RAM for one strip frame, scales each GRB word
//                by the frame's latched brightness, hands it to the serializer
//                and then holds the data line low for the latch gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_frame_scheduler
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_LEDS       = 8,
    parameter int unsigned ADDR_W         = 3,
    parameter int unsigned RESET_CYCLES   = DEFAULT_RESET_CYCLES,
    parameter int unsigned REFRESH_CYCLES = 1000000
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              frame_req_i,
    input  logic              auto_en_i,
    input  logic [7:0]        brightness_i,
    output logic [ADDR_W-1:0] pix_addr_o,
    output logic              pix_rd_en_o,
    input  logic [23:0]       pix_rdata_i,
    output logic [23:0]       px_data_o,
    output logic              px_load_o,
    input  logic              px_busy_i,
    input  logic              px_line_i,
    output logic              ws2812_out_o,
    output logic              frame_busy_o,
    output logic              frame_done_o
);

    localparam int unsigned       LAT_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RESET_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LED_LAST = ADDR_W'(NUM_LEDS - 1);

    state_e            state_q,    state_d;
    logic [ADDR_W-1:0] led_idx_q,  led_idx_d;
    logic              pending_q,  pending_d;
    logic [7:0]        bright_q,   bright_d;
    logic [LAT_W-1:0]  lat_cnt_q,  lat_cnt_d;
    logic [ADDR_W-1:0] pix_addr_q;
    logic [23:0]       px_data_q,  px_data_d;
    logic              frame_done_q, frame_done_d;
    logic              pend_clr;
    logic              refresh_tick;

    ws2812_refresh_timer #(
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .tick_o    (refresh_tick)
    );

    // Next-state, frame bookkeeping and state-decoded control outputs
    always_comb begin
        state_d      = state_q;
        led_idx_d    = led_idx_q;
        bright_d     = bright_q;
        lat_cnt_d    = lat_cnt_q;
        frame_done_d = 1'b0;
        pend_clr     = 1'b0;
        pix_rd_en_o  = 1'b0;
        px_load_o    = 1'b0;
        ws2812_out_o = 1'b0;
        frame_busy_o = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d   = ST_FETCH;
                    pend_clr  = 1'b1;
                    led_idx_d = '0;
                    bright_d  = brightness_i;
                end
            end
            ST_FETCH: begin
                pix_rd_en_o  = 1'b1;
                ws2812_out_o = px_line_i;
                state_d      = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                ws2812_out_o = px_line_i;
                state_d      = ST_KICK;
            end
            ST_KICK: begin
                px_load_o    = 1'b1;
                ws2812_out_o = px_line_i;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                ws2812_out_o = px_line_i;
                // The serializer raises busy the cycle after the load, so the
                // first WAIT cycle never exits early.
                if (!px_busy_i) begin
                    if (led_idx_q == LED_LAST) begin
                        state_d   = ST_LATCH;
                        lat_cnt_d = '0;
                    end else begin
                        led_idx_d = led_idx_q + ADDR_W'(1);
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_LATCH: begin
                if (lat_cnt_q == LAT_LAST) begin
                    frame_done_d = 1'b1;
                    lat_cnt_d    = '0;
                    // A request that arrived mid-frame starts straight away
                    if (pending_q) begin
                        state_d   = ST_FETCH;
                        pend_clr  = 1'b1;
                        led_idx_d = '0;
                        bright_d  = brightness_i;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // One-deep request flag; a new request wins over a same-cycle clear
    always_comb begin
        pending_d = frame_req_i | (refresh_tick & auto_en_i) | (pending_q & ~pend_clr);
    end

    // Capture-and-scale of the pixel word read in FETCH
    always_comb begin
        px_data_d = (state_q == ST_CAPTURE) ? scale_grb(pix_rdata_i, bright_q) : px_data_q;
    end

    // State and datapath registers; reset aborts any frame at once
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            led_idx_q    <= '0;
            pending_q    <= 1'b0;
            bright_q     <= 8'd0;
            lat_cnt_q    <= '0;
            pix_addr_q   <= '0;
            px_data_q    <= 24'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            led_idx_q    <= led_idx_d;
            pending_q    <= pending_d;
            bright_q     <= bright_d;
            lat_cnt_q    <= lat_cnt_d;
            pix_addr_q   <= led_idx_d;
            px_data_q    <= px_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pix_addr_o   = pix_addr_q;
    assign px_data_o    = px_data_q;
    assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ws2812_frame_scheduler
//  Description : Scoreboard bench for the WS2812 frame scheduler with a pixel
//                RAM model, a serializer model and a timing reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_frame_scheduler;

    localparam int NUM_LEDS       = 4;
    localparam int ADDR_W         = 2;
    localparam int RESET_CYCLES   = 20;
    localparam int REFRESH_CYCLES = 200;
    localparam int BUSY_CYCLES    = 30;
    // request edge -> pending -> IDLE exit -> FETCH -> CAPTURE -> KICK
    localparam int REQ_TO_LOAD    = 4;
    // frame_done cycle is FETCH; CAPTURE, then KICK
    localparam int DONE_TO_LOAD   = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              frame_req = 1'b0;
    logic              auto_en = 1'b0;
    logic [7:0]        brightness = 8'd0;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_rd_en;
    logic [23:0]       pix_rdata = 24'd0;
    logic [23:0]       px_data;
    logic              px_load;
    logic              px_busy = 1'b0;
    logic              px_line = 1'b0;
    logic              ws2812_out;
    logic              frame_busy;
    logic              frame_done;

    ws2812_frame_scheduler #(
        .NUM_LEDS       (NUM_LEDS),
        .ADDR_W         (ADDR_W),
        .RESET_CYCLES   (RESET_CYCLES),
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .frame_req_i  (frame_req),
        .auto_en_i    (auto_en),
        .brightness_i (brightness),
        .pix_addr_o   (pix_addr),
        .pix_rd_en_o  (pix_rd_en),
        .pix_rdata_i  (pix_rdata),
        .px_data_o    (px_data),
        .px_load_o    (px_load),
        .px_busy_i    (px_busy),
        .px_line_i    (px_line),
        .ws2812_out_o (ws2812_out),
        .frame_busy_o (frame_busy),
        .frame_done_o (frame_done)
    );

    typedef struct {
        logic [23:0] word;
        int          cyc;     // required load cycle, -1 when not pinned
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] ram [NUM_LEDS];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          pix_n    = 0;
    int          loads    = 0;
    int          dones    = 0;
    bit          gap_active = 0;
    bit          gap_bad    = 0;
    bit          line_bad   = 0;
    bit          idle_bad   = 0;
    bit          chain_flag = 0;
    int          gap_lo, gap_hi, done_exp;
    int          next_load_cyc = -1;

    always #5 clk = ~clk;

    // cycle index since reset release (cycle 0 is the one right after release)
    initial forever begin
        @(posedge clk);
        if (!reset_n) cyc = 0;
        else          cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference scaling: each channel times (b+1), divided by 256
    function automatic logic [23:0] ref_scale(input logic [23:0] w, input int b);
        logic [23:0] r;
        int          c;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            c = int'((w >> (8 * k)) & 24'hFF);
            r[8*k +: 8] = 8'((c * (b + 1)) / 256);
        end
        return r;
    endfunction

    task automatic push_frame(input int first_cyc);
        exp_t e;
        for (int i = 0; i < NUM_LEDS; i++) begin
            e.word = ref_scale(ram[i], int'(brightness));
            e.cyc  = (i == 0) ? first_cyc : -1;
            exp_q.push_back(e);
        end
    endtask

    task automatic randomize_ram();
        for (int i = 0; i < NUM_LEDS; i++) ram[i] = 24'($urandom);
    endtask

    // Called at posedge+1: request sampled at the coming edge
    task automatic send_frame();
        push_frame(cyc + REQ_TO_LOAD);
        frame_req = 1'b1;
        @(posedge clk); #1;
        frame_req = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || gap_active || frame_busy === 1'b1) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: frame not complete after %0d cycles", name, n);
        end
    endtask

    task automatic wait_pix(input int target, input string name);
        int n;
        n = 0;
        while (pix_n != target && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: pixel %0d never loaded, got %0d", name, target, pix_n);
        end
    endtask

    // Pixel RAM (1-cycle read latency) and serializer (busy for BUSY_CYCLES)
    initial begin
        bit                ld, rd;
        logic [ADDR_W-1:0] ad;
        int                left;
        ld = 0; rd = 0; ad = '0; left = 0;
        forever begin
            @(negedge clk);
            ld = px_load;
            rd = pix_rd_en;
            ad = pix_addr;
            @(posedge clk); #1;
            if (!reset_n) begin
                left = 0; ld = 0; rd = 0;
            end
            if (ld) left = BUSY_CYCLES;
            if (left > 0) begin
                px_busy = 1'b1;
                left--;
            end else begin
                px_busy = 1'b0;
            end
            px_line   = 1'($urandom_range(0, 1));
            pix_rdata = rd ? ram[ad] : 24'($urandom);
        end
    end

    // Monitor: pops the scoreboard on each load and checks frame timing
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset_n) begin
            exp_q.delete();
            pix_n = 0; gap_active = 0; gap_bad = 0; line_bad = 0;
            chain_flag = 0; next_load_cyc = -1;
        end else begin
            if (px_busy && (ws2812_out !== px_line || frame_busy !== 1'b1)) line_bad = 1;
            if (gap_active && cyc >= gap_lo && cyc <= gap_hi &&
                (ws2812_out !== 1'b0 || frame_busy !== 1'b1)) gap_bad = 1;
            if (exp_q.size() == 0 && !gap_active && ws2812_out !== 1'b0) idle_bad = 1;
            if (pix_rd_en) chk("pix_addr", 32'(pix_addr), 32'(pix_n));
            if (px_load) begin
                loads++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_load", 32'(loads), 32'(loads - 1));
                end else begin
                    e = exp_q.pop_front();
                    chk("px_data", px_data, e.word);
                    if (e.cyc >= 0) chk("load_cycle", cyc, e.cyc);
                    if (next_load_cyc >= 0) begin
                        chk("chain_load_cycle", cyc, next_load_cyc);
                        next_load_cyc = -1;
                    end
                    pix_n++;
                    if (pix_n == NUM_LEDS) begin
                        pix_n      = 0;
                        gap_lo     = cyc + BUSY_CYCLES + 2;
                        gap_hi     = cyc + BUSY_CYCLES + 1 + RESET_CYCLES;
                        done_exp   = gap_hi + 1;
                        gap_active = 1;
                    end
                end
            end
            if (frame_done) begin
                dones++;
                if (!gap_active) begin
                    chk("unexpected_done", 32'(dones), 32'(dones - 1));
                end else begin
                    chk("done_cycle", cyc, done_exp);
                    chk("latch_gap_low", 32'(gap_bad), 0);
                    chk("line_follow", 32'(line_bad), 0);
                    if (chain_flag) begin
                        chk("chain_busy_held", 32'(frame_busy), 1);
                        next_load_cyc = cyc + DONE_TO_LOAD;
                        chain_flag    = 0;
                    end else begin
                        chk("busy_fall", 32'(frame_busy), 0);
                    end
                    gap_active = 0; gap_bad = 0; line_bad = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, t, saved_loads, saved_dones, n;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pix_addr",   32'(pix_addr),   0);
        chk("rst_pix_rd_en",  32'(pix_rd_en),  0);
        chk("rst_px_data",    32'(px_data),    0);
        chk("rst_px_load",    32'(px_load),    0);
        chk("rst_ws2812_out", 32'(ws2812_out), 0);
        chk("rst_frame_busy", 32'(frame_busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single unscaled frame, address order 0..3
        ram[0] = 24'hFF0000; ram[1] = 24'h00FF00; ram[2] = 24'h0000FF; ram[3] = 24'h123456;
        brightness = 8'd255;
        send_frame();
        wait_quiet("single_frame");

        // Scaling corner cases
        ram[0] = 24'hFF8001; ram[1] = 24'($urandom); ram[2] = 24'hFFFFFF; ram[3] = 24'($urandom);
        brightness = 8'd127;
        send_frame();
        wait_quiet("scale_127");
        brightness = 8'd0;
        send_frame();
        wait_quiet("scale_0");

        // Random frames
        for (int i = 0; i < 3; i++) begin
            randomize_ram();
            brightness = 8'($urandom_range(0, 255));
            send_frame();
            wait_quiet("random_frame");
        end

        // Request coalescing: three requests during pixel 1 -> one follow-on
        randomize_ram();
        brightness = 8'($urandom_range(0, 255));
        chain_flag = 1;
        send_frame();
        wait_pix(1, "coalesce");
        for (int i = 0; i < 3; i++) begin
            frame_req = 1'b1;
            @(posedge clk); #1;
            frame_req = 1'b0;
            @(posedge clk); #1;
        end
        push_frame(-1);
        wait_quiet("coalesce");

        // Mid-frame brightness change keeps the old scale for this frame
        randomize_ram();
        brightness = 8'd200;
        send_frame();
        wait_pix(2, "mid_bright");
        brightness = 8'd50;
        wait_quiet("mid_bright");
        send_frame();
        wait_quiet("new_bright");

        // Auto refresh: one frame per tick (tick in cycles with index%200 == 199)
        randomize_ram();
        brightness = 8'($urandom_range(0, 255));
        c0 = cyc;
        auto_en = 1'b1;
        t = c0 + (REFRESH_CYCLES - 1 - (c0 % REFRESH_CYCLES));
        for (int k = 0; k < 3; k++) push_frame(t + k * REFRESH_CYCLES + REQ_TO_LOAD);
        n = 0;
        while (cyc < t + 2 * REFRESH_CYCLES + REQ_TO_LOAD + 2 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        wait_quiet("auto_refresh");
        auto_en = 1'b0;
        saved_loads = loads;
        repeat (450) @(posedge clk);
        #1;
        chk("auto_off_loads", loads, saved_loads);

        // Reset during WAIT aborts the frame
        randomize_ram();
        brightness = 8'($urandom_range(0, 255));
        send_frame();
        wait_pix(2, "reset_abort");
        n = 0;
        while (px_busy !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reset_in_wait_busy", 32'(px_busy), 1);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("abort_ws2812_out", 32'(ws2812_out), 0);
        chk("abort_px_load",    32'(px_load),    0);
        chk("abort_pix_rd_en",  32'(pix_rd_en),  0);
        chk("abort_frame_busy", 32'(frame_busy), 0);
        chk("abort_frame_done", 32'(frame_done), 0);
        chk("abort_pix_addr",   32'(pix_addr),   0);
        chk("abort_px_data",    32'(px_data),    0);
        saved_dones = dones;
        saved_loads = loads;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        chk("abort_no_done",    dones, saved_dones);
        chk("abort_no_loads",   loads, saved_loads);
        chk("abort_idle_busy",  32'(frame_busy), 0);
        chk("idle_line_low",    32'(idle_bad), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
